// File: rtl/spiker_frame_pkg.sv
// Shared state encoding and sizing helper for the spike frame sequencer.
package spiker_frame_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        STREAM   = 2'd1,
        WAIT_RES = 2'd2
    } state_t;

    function automatic int ceil_div(input int num, input int den);
        return (num + den - 1) / den;
    endfunction

endpackage

// File: rtl/spiker_frame_buffer.sv
// Spike frame storage: word-wide write port, CHUNK_W-wide beat read mux.
// Latency: write commits on the next edge; read is combinational and already reflects a same-cycle write.
// Backpressure: none; the caller gates writes.
module spiker_frame_buffer
    import spiker_frame_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int N_SPIKES = 784,
    parameter int CHUNK_W  = 16,
    parameter int ADDR_W   = 5,
    parameter int BEAT_W   = 6
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [WORD_W-1:0]  wr_data_i,
    input  logic [BEAT_W-1:0]  rd_beat_i,
    output logic [CHUNK_W-1:0] rd_dat_o
);

    localparam int N_WORDS = ceil_div(N_SPIKES, WORD_W);
    localparam int N_BEATS = ceil_div(N_SPIKES, CHUNK_W);
    localparam int STORE_W = N_WORDS * WORD_W;
    localparam int FLAT_W  = (N_BEATS * CHUNK_W > STORE_W) ? N_BEATS * CHUNK_W : STORE_W;

    logic [WORD_W-1:0] words [N_WORDS];
    logic [FLAT_W-1:0] flat;

    // Spike positions past N_SPIKES never hold a 1, so padding reads back as 0.
    function automatic logic [WORD_W-1:0] word_mask(input int w);
        logic [WORD_W-1:0] m;
        for (int k = 0; k < WORD_W; k++) begin
            m[k] = ((w * WORD_W + k) < N_SPIKES);
        end
        return m;
    endfunction

    always_ff @(posedge clk_i) begin
        for (int w = 0; w < N_WORDS; w++) begin
            if (rst_i) begin
                words[w] <= '0;
            end else if (wr_en_i && wr_addr_i == ADDR_W'(w)) begin
                words[w] <= wr_data_i & word_mask(w);
            end
        end
    end

    // Forward the in-flight write so a start in the same cycle streams the new word.
    always_comb begin
        flat = '0;
        for (int w = 0; w < N_WORDS; w++) begin
            if (wr_en_i && wr_addr_i == ADDR_W'(w)) begin
                flat[w*WORD_W +: WORD_W] = wr_data_i & word_mask(w);
            end else begin
                flat[w*WORD_W +: WORD_W] = words[w];
            end
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int b = 0; b < N_BEATS; b++) begin
            if (rd_beat_i == BEAT_W'(b)) begin
                rd_dat_o = flat[b*CHUNK_W +: CHUNK_W];
            end
        end
    end

endmodule

// File: rtl/spiker_frame_sequencer.sv
// Streams a stored spike frame to the core for N timesteps, then captures the classification result.
// Latency: start -> first valid beat 1 cycle; result strobe -> done/res_o 1 cycle.
// Backpressure: valid/ready on the beat stream; data and last hold while stalled, no bubbles between beats.
module spiker_frame_sequencer
    import spiker_frame_pkg::*;
#(
    parameter int WORD_W   = 32,
    parameter int N_SPIKES = 784,
    parameter int CHUNK_W  = 16,
    parameter int RES_W    = 32,
    parameter int STEP_W   = 8
) (
    input  logic                                               clk_i,
    input  logic                                               rst_i,
    input  logic                                               wr_en_i,
    input  logic [$clog2(ceil_div(N_SPIKES, WORD_W))-1:0]      wr_addr_i,
    input  logic [WORD_W-1:0]                                  wr_data_i,
    input  logic                                               start_i,
    input  logic                                               abort_i,
    input  logic [STEP_W-1:0]                                  timesteps_i,
    output logic                                               busy_o,
    output logic                                               done_o,
    output logic                                               wr_err_o,
    output logic                                               spk_valid_o,
    input  logic                                               spk_ready_i,
    output logic [CHUNK_W-1:0]                                 spk_data_o,
    output logic                                               spk_last_o,
    input  logic                                               res_valid_i,
    input  logic [RES_W-1:0]                                   res_data_i,
    output logic [RES_W-1:0]                                   res_o
);

    localparam int N_WORDS = ceil_div(N_SPIKES, WORD_W);
    localparam int N_BEATS = ceil_div(N_SPIKES, CHUNK_W);
    localparam int ADDR_W  = $clog2(N_WORDS);
    localparam int BEAT_W  = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic [BEAT_W-1:0]   rd_beat;
    logic [STEP_W-1:0]   step_cnt;
    logic [STEP_W-1:0]   steps;
    logic [CHUNK_W-1:0]  rd_dat;
    logic                hs;
    logic                beat_wrap;
    logic                buf_wr_en;

    assign hs         = spk_valid_o && spk_ready_i;
    assign beat_wrap  = (beat_cnt == BEAT_W'(N_BEATS - 1));
    assign buf_wr_en  = wr_en_i && (state == IDLE);
    assign spk_last_o = spk_valid_o && beat_wrap;

    // Index of the beat to present next cycle; the payload register is loaded from it.
    always_comb begin
        rd_beat = beat_cnt;
        if (state == IDLE) begin
            rd_beat = '0;
        end else if (hs) begin
            rd_beat = beat_wrap ? '0 : beat_cnt + 1'b1;
        end
    end

    spiker_frame_buffer #(
        .WORD_W   (WORD_W),
        .N_SPIKES (N_SPIKES),
        .CHUNK_W  (CHUNK_W),
        .ADDR_W   (ADDR_W),
        .BEAT_W   (BEAT_W)
    ) u_buf (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (buf_wr_en),
        .wr_addr_i (wr_addr_i),
        .wr_data_i (wr_data_i),
        .rd_beat_i (rd_beat),
        .rd_dat_o  (rd_dat)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            step_cnt    <= '0;
            steps       <= '0;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            wr_err_o    <= 1'b0;
            spk_valid_o <= 1'b0;
            spk_data_o  <= '0;
            res_o       <= '0;
        end else begin
            done_o   <= 1'b0;
            wr_err_o <= wr_en_i && (state != IDLE);
            case (state)
                IDLE: begin
                    if (start_i) begin
                        state       <= STREAM;
                        steps       <= (timesteps_i == '0) ? STEP_W'(1) : timesteps_i;
                        beat_cnt    <= '0;
                        step_cnt    <= '0;
                        busy_o      <= 1'b1;
                        spk_valid_o <= 1'b1;
                        spk_data_o  <= rd_dat;
                    end
                end
                STREAM: begin
                    if (abort_i) begin
                        state       <= IDLE;
                        busy_o      <= 1'b0;
                        spk_valid_o <= 1'b0;
                        spk_data_o  <= '0;
                    end else if (hs) begin
                        beat_cnt   <= rd_beat;
                        spk_data_o <= rd_dat;
                        if (beat_wrap) begin
                            if (step_cnt == steps - 1'b1) begin
                                state       <= WAIT_RES;
                                spk_valid_o <= 1'b0;
                                spk_data_o  <= '0;
                            end else begin
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end
                    end
                end
                WAIT_RES: begin
                    if (abort_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                    end else if (res_valid_i) begin
                        state  <= IDLE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        res_o  <= res_data_i;
                    end
                end
                default: begin
                    state       <= IDLE;
                    busy_o      <= 1'b0;
                    spk_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spiker_frame_sequencer.sv
module tb_spiker_frame_sequencer;

    localparam int N_WORDS = 25;
    localparam int N_BEATS = 49;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        wr_en_i;
    logic [4:0]  wr_addr_i;
    logic [31:0] wr_data_i;
    logic        start_i;
    logic        abort_i;
    logic [7:0]  timesteps_i;
    logic        busy_o;
    logic        done_o;
    logic        wr_err_o;
    logic        spk_valid_o;
    logic        spk_ready_i;
    logic [15:0] spk_data_o;
    logic        spk_last_o;
    logic        res_valid_i;
    logic [31:0] res_data_i;
    logic [31:0] res_o;

    always #5 clk_i = ~clk_i;

    spiker_frame_sequencer dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_en_i     (wr_en_i),
        .wr_addr_i   (wr_addr_i),
        .wr_data_i   (wr_data_i),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .timesteps_i (timesteps_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .wr_err_o    (wr_err_o),
        .spk_valid_o (spk_valid_o),
        .spk_ready_i (spk_ready_i),
        .spk_data_o  (spk_data_o),
        .spk_last_o  (spk_last_o),
        .res_valid_i (res_valid_i),
        .res_data_i  (res_data_i),
        .res_o       (res_o)
    );

    typedef struct packed {
        logic [15:0] dat;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [31:0] model [N_WORDS];
    logic [31:0] last_res;
    int          total = 0;
    int          bad = 0;
    int          hs_cnt = 0;
    int          last_cnt = 0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_dat = '0;
    logic        prev_last = 1'b0;

    // Beat monitor: samples on the falling edge, where inputs and outputs are settled.
    always @(negedge clk_i) begin
        if (!rst_i && spk_valid_o) begin
            if (prev_stall) begin
                total++;
                if (spk_data_o !== prev_dat || spk_last_o !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: data=%h last=%b required data=%h last=%b",
                             spk_data_o, spk_last_o, prev_dat, prev_last);
                end
            end
            if (spk_ready_i && !abort_i) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_beat: data=%h last=%b required no beat", spk_data_o, spk_last_o);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (spk_data_o !== mon_e.dat || spk_last_o !== mon_e.last) begin
                        bad++;
                        $display("FAIL beat_%0d: data=%h last=%b required data=%h last=%b",
                                 hs_cnt, spk_data_o, spk_last_o, mon_e.dat, mon_e.last);
                    end
                end
                hs_cnt++;
                if (spk_last_o) last_cnt++;
            end
        end
        prev_stall = !rst_i && spk_valid_o && !spk_ready_i && !abort_i;
        prev_dat   = spk_data_o;
        prev_last  = spk_last_o;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        wr_en_i   = 1'b1;
        wr_addr_i = a[4:0];
        wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic load_model(input logic [31:0] d);
        for (int w = 0; w < N_WORDS; w++) begin
            model[w] = (w == N_WORDS - 1) ? (d & 32'h0000FFFF) : d;
        end
    endtask

    task automatic write_random_frame();
        logic [31:0] d;
        for (int w = 0; w < N_WORDS; w++) begin
            d = $urandom();
            write_word(w, d);
            model[w] = (w == N_WORDS - 1) ? (d & 32'h0000FFFF) : d;
        end
    endtask

    task automatic push_frame(input int steps);
        logic [N_WORDS*32-1:0] flat;
        beat_t e;
        for (int w = 0; w < N_WORDS; w++) flat[w*32 +: 32] = model[w];
        for (int s = 0; s < steps; s++) begin
            for (int b = 0; b < N_BEATS; b++) begin
                e.dat  = flat[b*16 +: 16];
                e.last = (b == N_BEATS - 1);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic start_frame(input logic [7:0] ts);
        push_frame((ts == 0) ? 1 : int'(ts));
        hs_cnt      = 0;
        last_cnt    = 0;
        timesteps_i = ts;
        start_i     = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic run_stream(input bit rand_ready, output int cycles);
        cycles = 0;
        while (spk_valid_o && cycles < 3000) begin
            spk_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cycles++;
        end
        spk_ready_i = 1'b1;
        if (spk_valid_o) begin
            total++;
            bad++;
            $display("FAIL stream_timeout: valid=%b after %0d cycles required 0", spk_valid_o, cycles);
        end
    endtask

    task automatic finish_frame(input logic [31:0] r);
        res_valid_i = 1'b1;
        res_data_i  = r;
        tick();
        res_valid_i = 1'b0;
        total++;
        if (done_o !== 1'b1 || res_o !== r || busy_o !== 1'b0) begin
            bad++;
            $display("FAIL completion: done=%b res=%h busy=%b required done=1 res=%h busy=0",
                     done_o, res_o, busy_o, r);
        end
        last_res = r;
        tick();
        total++;
        if (done_o !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse: done=%b required 0", done_o);
        end
    endtask

    task automatic check_frame_end(input string name, input int cycles, input int exp_cycles, input int exp_last);
        total++;
        if (cycles !== exp_cycles || hs_cnt !== exp_cycles || last_cnt !== exp_last || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL %s: cycles=%0d beats=%0d lasts=%0d left=%0d required %0d/%0d/%0d/0",
                     name, cycles, hs_cnt, last_cnt, exp_q.size(), exp_cycles, exp_cycles, exp_last);
        end
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        tick();
        tick();
        total++;
        if ({busy_o, done_o, wr_err_o, spk_valid_o, spk_last_o} !== 5'b0 || spk_data_o !== 16'h0 || res_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_state: busy=%b done=%b err=%b vld=%b last=%b data=%h res=%h required all 0",
                     busy_o, done_o, wr_err_o, spk_valid_o, spk_last_o, spk_data_o, res_o);
        end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_defaults();
        int cycles;
        for (int w = 0; w < N_WORDS; w++) write_word(w, 32'hFFFF_FFFF);
        load_model(32'hFFFF_FFFF);
        start_frame(8'd1);
        total++;
        if (spk_valid_o !== 1'b1 || busy_o !== 1'b1) begin
            bad++;
            $display("FAIL start_latency: vld=%b busy=%b required 1 1", spk_valid_o, busy_o);
        end
        run_stream(1'b0, cycles);
        check_frame_end("defaults_frame", cycles, N_BEATS, 1);
        finish_frame(32'h7);
    endtask

    task automatic test_padding();
        total++;
        if (dut.u_buf.words[24] !== 32'h0000FFFF) begin
            bad++;
            $display("FAIL pad_word24: stored=%h required 0000ffff", dut.u_buf.words[24]);
        end
        write_word(24, 32'hABCD_1234);
        model[24] = 32'h0000_1234;
        tick();
        total++;
        if (dut.u_buf.words[24] !== 32'h0000_1234) begin
            bad++;
            $display("FAIL pad_word24_mixed: stored=%h required 00001234", dut.u_buf.words[24]);
        end
    endtask

    task automatic test_backpressure();
        int cycles;
        write_random_frame();
        start_frame(8'd1);
        run_stream(1'b1, cycles);
        total++;
        if (hs_cnt !== N_BEATS || last_cnt !== 1 || exp_q.size() !== 0) begin
            bad++;
            $display("FAIL backpressure_frame: beats=%0d lasts=%0d left=%0d required %0d 1 0",
                     hs_cnt, last_cnt, exp_q.size(), N_BEATS);
        end
        finish_frame($urandom());
    endtask

    task automatic test_multistep();
        int cycles;
        write_random_frame();
        start_frame(8'd3);
        run_stream(1'b0, cycles);
        check_frame_end("three_steps", cycles, 3 * N_BEATS, 3);
        finish_frame(32'h0000_0003);
        start_frame(8'd0);
        run_stream(1'b0, cycles);
        check_frame_end("zero_steps", cycles, N_BEATS, 1);
        finish_frame(32'h0000_0009);
    endtask

    task automatic test_write_start();
        int cycles;
        model[0] = 32'hA5A5_5A5A;
        push_frame(1);
        hs_cnt      = 0;
        last_cnt    = 0;
        timesteps_i = 8'd1;
        wr_en_i     = 1'b1;
        wr_addr_i   = 5'd0;
        wr_data_i   = 32'hA5A5_5A5A;
        start_i     = 1'b1;
        tick();
        wr_en_i = 1'b0;
        start_i = 1'b0;
        total++;
        if (spk_data_o !== 16'h5A5A) begin
            bad++;
            $display("FAIL write_start_beat0: data=%h required 5a5a", spk_data_o);
        end
        run_stream(1'b0, cycles);
        check_frame_end("write_start_frame", cycles, N_BEATS, 1);
        finish_frame(32'h1234_5678);
    endtask

    task automatic test_errors();
        int cycles;
        start_frame(8'd1);
        wr_en_i   = 1'b1;
        wr_addr_i = 5'd0;
        wr_data_i = ~model[0];
        tick();
        wr_en_i = 1'b0;
        total++;
        if (wr_err_o !== 1'b1) begin
            bad++;
            $display("FAIL wr_err_busy: err=%b required 1", wr_err_o);
        end
        start_i     = 1'b1;
        timesteps_i = 8'd5;
        tick();
        start_i = 1'b0;
        total++;
        if (wr_err_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_err_pulse: err=%b required 0", wr_err_o);
        end
        run_stream(1'b0, cycles);
        check_frame_end("start_while_busy", cycles + 2, N_BEATS, 1);
        finish_frame(32'hCAFE_0001);
        write_word(25, 32'hFFFF_FFFF);
        total++;
        if (wr_err_o !== 1'b0) begin
            bad++;
            $display("FAIL wr_oob_silent: err=%b required 0", wr_err_o);
        end
        start_frame(8'd1);
        run_stream(1'b0, cycles);
        check_frame_end("buffer_unchanged", cycles, N_BEATS, 1);
        finish_frame(32'hCAFE_0002);
    endtask

    task automatic test_abort();
        int cycles;
        start_frame(8'd1);
        for (int i = 0; i < 10; i++) tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || spk_valid_o !== 1'b0 || done_o !== 1'b0 || hs_cnt !== 10 || exp_q.size() !== N_BEATS - 10) begin
            bad++;
            $display("FAIL abort_stream: busy=%b vld=%b done=%b beats=%0d left=%0d required 0 0 0 10 %0d",
                     busy_o, spk_valid_o, done_o, hs_cnt, exp_q.size(), N_BEATS - 10);
        end
        exp_q.delete();
        res_valid_i = 1'b1;
        res_data_i  = 32'hDEAD_BEEF;
        tick();
        res_valid_i = 1'b0;
        total++;
        if (done_o !== 1'b0 || res_o !== last_res) begin
            bad++;
            $display("FAIL res_in_idle: done=%b res=%h required 0 %h", done_o, res_o, last_res);
        end
        start_frame(8'd1);
        run_stream(1'b0, cycles);
        check_frame_end("restart_after_abort", cycles, N_BEATS, 1);
        abort_i     = 1'b1;
        res_valid_i = 1'b1;
        res_data_i  = 32'hBAD0_0BAD;
        tick();
        abort_i     = 1'b0;
        res_valid_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || res_o !== last_res) begin
            bad++;
            $display("FAIL abort_wait_res: busy=%b done=%b res=%h required 0 0 %h", busy_o, done_o, res_o, last_res);
        end
    endtask

    task automatic test_reset_midrun();
        int cycles;
        start_frame(8'd1);
        run_stream(1'b0, cycles);
        check_frame_end("pre_reset_frame", cycles, N_BEATS, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        total++;
        if ({busy_o, done_o, wr_err_o, spk_valid_o, spk_last_o} !== 5'b0 || spk_data_o !== 16'h0 || res_o !== 32'h0) begin
            bad++;
            $display("FAIL reset_wait_res: busy=%b done=%b err=%b vld=%b last=%b data=%h res=%h required all 0",
                     busy_o, done_o, wr_err_o, spk_valid_o, spk_last_o, spk_data_o, res_o);
        end
        load_model(32'h0);
        start_frame(8'd2);
        run_stream(1'b0, cycles);
        check_frame_end("cleared_frame", cycles, 2 * N_BEATS, 2);
        finish_frame(32'h0000_0055);
    endtask

    initial begin
        rst_i       = 1'b1;
        wr_en_i     = 1'b0;
        wr_addr_i   = '0;
        wr_data_i   = '0;
        start_i     = 1'b0;
        abort_i     = 1'b0;
        timesteps_i = 8'd1;
        spk_ready_i = 1'b1;
        res_valid_i = 1'b0;
        res_data_i  = '0;
        last_res    = '0;
        load_model(32'h0);

        test_reset();
        test_defaults();
        test_padding();
        test_backpressure();
        test_multistep();
        test_write_start();
        test_errors();
        test_abort();
        test_reset_midrun();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
